// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word link (receiver and transmitter).
// Holds the frame state encoding and the default data width.
package serial_word_receiver_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_word_receiver_sipo_reg.sv
// sipo_reg: WIDTH-bit serial-in / parallel-out register, LSB-first.
// Ports:
//   clk   - clock
//   clr_n - asynchronous active-low clear
//   shift - shift enable; din enters at the MSB, contents move toward the LSB
//   din   - serial input bit
//   q     - parallel contents
module sipo_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // After WIDTH shifts the first bit received sits in q[0].
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (shift) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: assembles start/data/stop frames sampled on bit_en
// into parallel words and offers them on a valid/ready handshake.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   bit_en       - bit strobe; in is sampled only when high
//   in           - serial line, idle high
//   ready        - downstream accepts data_out when valid is high
//   clr_ovr      - clears the sticky overrun flag
//   data_out     - last good received word
//   valid        - data_out holds an unconsumed word
//   frame_err    - one-cycle pulse on a bad stop bit
//   overrun      - sticky; a good word was dropped while valid was high
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_en,
  input  logic             in,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg;
  logic             shift_c;
  logic             stop_good_c;
  logic             frame_err_d;
  logic             load_c;
  logic             drop_c;

  // Data shift register.
  sipo_reg #(.WIDTH(WIDTH)) u_sreg (
    .clk   (clk),
    .clr_n (reset_n),
    .shift (shift_c),
    .din   (in),
    .q     (sreg)
  );

  // State and bit counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; nothing advances without a bit strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_c     = 1'b0;
    stop_good_c = 1'b0;
    frame_err_d = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_c = 1'b1;
          // Park the counter at zero on the last bit so it never wraps mid-frame.
          if (cnt_q == CNT_LAST) begin
            state_d = STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (in) begin
            stop_good_c = 1'b1;
            state_d     = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
        BREAK: begin
          // Wait for the line to return high so a held-low line cannot start a frame.
          if (in) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A good word loads if the output slot is free or is being drained this cycle.
  assign load_c = stop_good_c & (~valid | ready);
  assign drop_c = stop_good_c & valid & ~ready;

  // Output word, handshake and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_err_d;
      if (load_c) begin
        data_out <= sreg;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (drop_c) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver (WIDTH=8). Frames are built from
// words; the reference model works at word/handshake level from what was sent.
module tb_serial_word_receiver;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset_n;
  logic         bit_en;
  logic         in;
  logic         ready;
  logic         clr_ovr;
  logic [W-1:0] data_out;
  logic         valid;
  logic         frame_err;
  logic         overrun;

  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model state
  logic [W-1:0] exp_data;
  logic         exp_valid;
  logic         exp_ferr;
  logic         exp_ovr;

  // Stimulus controls
  logic tb_ready;
  logic tb_clr;
  logic rdy_rand;
  logic clr_rand;
  logic hs_on_stop;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_en    (bit_en),
    .in        (in),
    .ready     (ready),
    .clr_ovr   (clr_ovr),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".data"},  32'(data_out),  32'(exp_data));
    check_eq({tag, ".valid"}, 32'(valid),     32'(exp_valid));
    check_eq({tag, ".ferr"},  32'(frame_err), 32'(exp_ferr));
    check_eq({tag, ".ovr"},   32'(overrun),   32'(exp_ovr));
  endtask

  // One clock: apply inputs, advance, update model, compare.
  // good/bad mark the stop-bit strobe of a frame carrying word w.
  task automatic step(input logic ben, input logic din, input logic good,
                      input logic [W-1:0] w, input logic bad);
    logic r;
    logic c;
    logic dropped;
    r = rdy_rand ? 1'($urandom_range(0, 1)) : tb_ready;
    if (good && hs_on_stop) r = 1'b1;
    c = clr_rand ? ($urandom_range(0, 7) == 0) : tb_clr;
    bit_en  = ben;
    in      = din;
    ready   = r;
    clr_ovr = c;
    @(posedge clk);
    #1;
    dropped = good && exp_valid && !r;
    if (good && !dropped) begin
      exp_data  = w;
      exp_valid = 1'b1;
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
    if (dropped)  exp_ovr = 1'b1;
    else if (c)   exp_ovr = 1'b0;
    exp_ferr = bad;
    check_outputs("cyc");
  endtask

  task automatic send_bit(input logic b, input int gap, input logic good,
                          input logic [W-1:0] w, input logic bad);
    for (int g = 0; g < gap; g++) step(1'b0, b, 1'b0, '0, 1'b0);
    step(1'b1, b, good, w, bad);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stop_b, input int gap);
    send_bit(1'b0, gap, 1'b0, '0, 1'b0);
    for (int i = 0; i < int'(W); i++) send_bit(w[i], gap, 1'b0, '0, 1'b0);
    send_bit(stop_b, gap, stop_b, w, !stop_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
    check_outputs(tag);
    @(posedge clk);
    #1;
    check_outputs(tag);
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    bit_en     = 1'b0;
    in         = 1'b1;
    ready      = 1'b0;
    clr_ovr    = 1'b0;
    tb_ready   = 1'b0;
    tb_clr     = 1'b0;
    rdy_rand   = 1'b0;
    clr_rand   = 1'b0;
    hs_on_stop = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    apply_reset("reset");
    idle(2);

    // Continuous strobe, ready high: one-cycle valid
    tb_ready = 1'b1;
    send_frame(8'hA6, 1'b1, 0);
    idle(3);

    // Strobe every 4th clock
    send_frame(8'h3C, 1'b1, 3);
    idle(3);

    // Back-to-back words with ready low: second one dropped
    tb_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    check_eq("ovr.data", 32'(data_out), 32'h11);
    check_eq("ovr.flag", 32'(overrun), 32'h1);
    idle(2);
    tb_clr = 1'b1;
    idle(1);
    tb_clr = 1'b0;
    check_eq("ovr.clr", 32'(overrun), 32'h0);
    tb_ready = 1'b1;
    idle(1);
    check_eq("ovr.drain", 32'(valid), 32'h0);
    idle(2);

    // Bad stop bit, line held low, then recovery
    send_frame(8'h55, 1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0, 1'b0, '0, 1'b0);
    send_bit(1'b1, 0, 1'b0, '0, 1'b0);
    send_frame(8'h0F, 1'b1, 0);
    check_eq("brk.word", 32'(data_out), 32'h0F);
    idle(3);

    // Reset in the middle of a frame
    send_bit(1'b0, 0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i), 0, 1'b0, '0, 1'b0);
    apply_reset("midrst");
    idle(3);
    send_frame(8'h81, 1'b1, 1);
    check_eq("midrst.word", 32'(data_out), 32'h81);
    idle(3);

    // New word loads in the same cycle the old one is accepted
    tb_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 0);
    hs_on_stop = 1'b1;
    send_frame(8'hC3, 1'b1, 0);
    hs_on_stop = 1'b0;
    check_eq("hs.data", 32'(data_out), 32'hC3);
    check_eq("hs.valid", 32'(valid), 32'h1);
    check_eq("hs.ovr", 32'(overrun), 32'h0);
    tb_ready = 1'b1;
    idle(2);

    // Randomised frames, gaps, errors, handshake and clears
    rdy_rand = 1'b1;
    clr_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      logic [W-1:0] w;
      logic         bad;
      int           gap;
      w   = W'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(w, !bad, gap);
      if (bad) begin
        int lows;
        lows = int'($urandom_range(0, 3));
        for (int i = 0; i < lows; i++) send_bit(1'b0, gap, 1'b0, '0, 1'b0);
        send_bit(1'b1, gap, 1'b0, '0, 1'b0);
      end
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
    end
    rdy_rand = 1'b0;
    clr_rand = 1'b0;
    tb_ready = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
